dup_range_n: RTL and testbench
==============================

// Module: dup_range_n
// PURPOSE
//  Parametrised generator: for i in range(base, limit, step), emits each value DUP times as a (value, copy) tuple.
//  Range stepping is built in; no child generator instance. Signed ranges in both directions.
//  Built-in overflow termination. Ready/valid output; one beat per cycle when the consumer holds _ready high.
//  Consumers are other generated modules or a testbench, through the standard generator port set.
// PARAMETERS
//  WIDTH  32  width of base/limit/step and of _0 (signed two's complement)
//  DUP    2   copies emitted per range value; legal 1..255
// PORTS
//  _clock  input   1      sole clock; all logic on posedge
//  _reset  input   1      synchronous, active-high; forces DONE state
//  _start  input   1      capture base/limit/step this cycle, start generating; wins over _reset
//  base    input   WIDTH  first value (signed)
//  limit   input   WIDTH  exclusive bound (signed)
//  step    input   WIDTH  increment (signed; 0 means empty range)
//  _ready  input   1      consumer can accept a beat this cycle
//  _valid  output  1      _0/_1 hold a valid beat
//  _done   output  1      high while generator is finished and no beat is pending
//  _0      output  WIDTH  current range value i
//  _1      output  8      copy index k, 0..DUP-1
// BEHAVIOUR
//  Reset (_reset=1, _start=0): next edge gives _valid=0, _done=1, _0=0, _1=0, state DONE.
//  States:
//   DONE: _done=1, _valid=0; leaves only on _start.
//   EMIT: a beat is presented or pending.
//  Transfer: occurs on an edge where _valid && _ready.
//   While _valid && !_ready, _0/_1/_valid hold stable.
//  Start at edge T:
//   Inputs are latched; any in-flight beat is dropped (restart, also mid-stream).
//   Empty range (step=0, or step>0 && base>=limit, or step<0 && base<=limit): DONE at T+1, _done=1, no beat.
//   Otherwise at T+1: _valid=1, _0=base, _1=0, _done=0.
//  On transfer:
//   If _1<DUP-1: next edge presents (_0, _1+1).
//   Else next = _0+step computed in WIDTH+1 bits. Continue iff next is in WIDTH range and
//    (step>0 ? next<limit : next>limit); then present (next, 0).
//   Out-of-range or overflowed next: _valid=0, _done=1 on the same edge. Never wraps.
//  Throughput: with _ready held high, N range values give DUP*N beats on consecutive cycles T+1..T+DUP*N.
//   _done rises at T+DUP*N+1.
//  _valid and _done are never both high.
//  _reset mid-stream (no _start): pending beat discarded; DONE next edge.
//  _start and _reset in the same cycle: start is honoured.
//  _ready is ignored while in DONE.
//  All comparisons are signed; limit/step are latched, so input changes after _start have no effect.
// TESTING
//  1 WIDTH=32 DUP=2, (0,10,2), _ready=1 -> beats (0,0)(0,1)(2,0)(2,1)..(8,0)(8,1): 10 beats T+1..T+10; _done=1 at T+11.
//  2 Same stimulus, _ready toggled 1,0,1,0 -> identical sequence; _0/_1 stable on every stalled cycle; no beat lost or duplicated.
//  3 (5,5,1) and (0,10,0) -> _valid never rises; _done=1 at T+1.
//  4 DUP=1, (10,0,-3) -> 10,7,4,1; then _done. DUP=3, (-2,0,1) -> -2,-2,-2,-1,-1,-1.
//  5 WIDTH=8 DUP=1, (120,127,5) -> 120,125, then done (130 overflows, no wrap to -126).
//    (100,-128,-100) -> 100,0,-100, then done.
//  6 (0,10,1) DUP=2: _reset after 3 transfers -> _valid=0 and _done=1 next edge.
//    Then _start+_reset together with (3,5,1) -> (3,0)(3,1)(4,0)(4,1).
//    _start mid-stream -> old beat dropped; new base presented at next edge.

Source files
------------

// File: rtl/dup_range_n.sv
// Range generator: walks range(base, limit, step) with signed stepping and emits every value DUP times
// as (value, copy) beats over a ready/valid port, stopping cleanly instead of wrapping on overflow.
module dup_range_n #(
  parameter int WIDTH = 32,
  parameter int DUP   = 2
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic [7:0]              _1
);

  typedef enum logic {S_DONE, S_EMIT} state_t;

  localparam logic [7:0] LAST_CPY = 8'(DUP - 1);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] val_q, val_d;
  logic signed [WIDTH-1:0] limit_q, limit_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic [7:0]              cpy_q, cpy_d;

  logic signed [WIDTH:0]   next_w;
  logic signed [WIDTH:0]   limit_w;
  logic                    next_fits;
  logic                    next_in_range;
  logic                    empty_range;

  // One guard bit above WIDTH exposes overflow of val + step without wrapping.
  function automatic logic fits_width(input logic signed [WIDTH:0] x);
    return x[WIDTH] == x[WIDTH-1];
  endfunction

  always_comb begin
    next_w        = $signed({val_q[WIDTH-1], val_q}) + $signed({step_q[WIDTH-1], step_q});
    limit_w       = $signed({limit_q[WIDTH-1], limit_q});
    next_fits     = fits_width(next_w);
    next_in_range = step_q[WIDTH-1] ? (next_w > limit_w) : (next_w < limit_w);
    empty_range   = (step == '0) ||
                    (!step[WIDTH-1] && (base >= limit)) ||
                    ( step[WIDTH-1] && (base <= limit));
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    limit_d = limit_q;
    step_d  = step_q;
    cpy_d   = cpy_q;
    if (_start) begin
      limit_d = limit;
      step_d  = step;
      val_d   = base;
      cpy_d   = '0;
      state_d = empty_range ? S_DONE : S_EMIT;
    end else if (_reset) begin
      state_d = S_DONE;
      val_d   = '0;
      cpy_d   = '0;
    end else if (state_q == S_EMIT && _ready) begin
      if (cpy_q != LAST_CPY) begin
        cpy_d = cpy_q + 8'd1;
      end else if (next_fits && next_in_range) begin
        val_d = next_w[WIDTH-1:0];
        cpy_d = '0;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge _clock) begin
    state_q <= state_d;
    val_q   <= val_d;
    limit_q <= limit_d;
    step_q  <= step_d;
    cpy_q   <= cpy_d;
  end

  assign _valid = (state_q == S_EMIT);
  assign _done  = (state_q == S_DONE);
  assign _0     = val_q;
  assign _1     = cpy_q;

endmodule

// File: tb/tb_dup_range_n.sv
// Scoreboarded directed bench for dup_range_n: three instances cover DUP=2/32-bit, DUP=3/32-bit
// and DUP=1/8-bit; a range model pushes expected beats and each accepted beat pops one.
module tb_dup_range_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ready, st_a, st_b, st_c;
  logic signed [31:0] base, limit, step;

  logic v_a, d_a, v_b, d_b, v_c, d_c;
  logic signed [31:0] o_a, o_b;
  logic signed [7:0]  o_c;
  logic [7:0] k_a, k_b, k_c;

  dup_range_n #(.WIDTH(32), .DUP(2)) u_a (
    ._clock(clk), ._reset(rst), ._start(st_a), .base(base), .limit(limit), .step(step),
    ._ready(ready), ._valid(v_a), ._done(d_a), ._0(o_a), ._1(k_a));
  dup_range_n #(.WIDTH(32), .DUP(3)) u_b (
    ._clock(clk), ._reset(rst), ._start(st_b), .base(base), .limit(limit), .step(step),
    ._ready(ready), ._valid(v_b), ._done(d_b), ._0(o_b), ._1(k_b));
  dup_range_n #(.WIDTH(8), .DUP(1)) u_c (
    ._clock(clk), ._reset(rst), ._start(st_c), .base(base[7:0]), .limit(limit[7:0]), .step(step[7:0]),
    ._ready(ready), ._valid(v_c), ._done(d_c), ._0(o_c), ._1(k_c));

  int sel;
  logic obs_v, obs_d;
  logic signed [31:0] obs_0;
  logic [7:0] obs_1;

  always_comb begin
    obs_v = v_a; obs_d = d_a; obs_0 = o_a; obs_1 = k_a;
    case (sel)
      1: begin obs_v = v_b; obs_d = d_b; obs_0 = o_b; obs_1 = k_b; end
      2: begin obs_v = v_c; obs_d = d_c; obs_0 = {{24{o_c[7]}}, o_c}; obs_1 = k_c; end
      default: ;
    endcase
  end

  typedef struct { longint v; longint k; } beat_t;
  beat_t exp_q[$];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference range walk with overflow stop at the instance width.
  task automatic push_exp(input longint b, input longint l, input longint s, input int dup, input int w);
    longint v, lo, hi;
    beat_t bt;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    if (s == 0) return;
    v = b;
    while ((s > 0 && v < l) || (s < 0 && v > l)) begin
      for (int k = 0; k < dup; k++) begin
        bt.v = v; bt.k = k;
        exp_q.push_back(bt);
      end
      v = v + s;
      if (v < lo || v > hi) break;
    end
  endtask

  task automatic start(input int which, input longint b, input longint l, input longint s, input bit with_rst);
    sel   = which;
    base  = 32'(b);
    limit = 32'(l);
    step  = 32'(s);
    rst   = with_rst;
    st_a  = (which == 0);
    st_b  = (which == 1);
    st_c  = (which == 2);
    @(negedge clk);
    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    rst  = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready toggles 1,0,1,0.
  // max_xfers > 0 returns one edge after that many transfers instead of waiting for done.
  task automatic run(input string tag, input int mode, input int max_xfers, input int exp_beats);
    bit   finished, prev_stall;
    int   xfers;
    logic signed [31:0] pv;
    logic [7:0] pk;
    beat_t bt;
    finished = 0; prev_stall = 0; xfers = 0; pv = '0; pk = '0;
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      if (obs_v && obs_d) check({tag, "_valid_and_done"}, 1, 0);
      if (obs_v) begin
        if (prev_stall) begin
          check({tag, "_stall_0"}, obs_0, pv);
          check({tag, "_stall_1"}, obs_1, pk);
        end
        ready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
        if (ready) begin
          if (exp_q.size() == 0) begin
            check({tag, "_extra_beat"}, obs_v, 0);
          end else begin
            bt = exp_q.pop_front();
            check({tag, "_0"}, obs_0, bt.v);
            check({tag, "_1"}, obs_1, bt.k);
          end
          xfers++;
        end
        prev_stall = !ready;
        pv = obs_0; pk = obs_1;
        @(negedge clk);
        if (max_xfers > 0 && xfers == max_xfers) finished = 1;
      end else begin
        prev_stall = 0;
        if (obs_d) begin
          finished = 1;
          check({tag, "_drain"}, exp_q.size(), 0);
          if (mode == 0) check({tag, "_done_cycle"}, cyc, exp_beats + 1);
        end else begin
          check({tag, "_idle_not_done"}, obs_d, 1);
          @(negedge clk);
        end
      end
    end
    if (!finished) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    base = '0; limit = '0; step = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("reset_valid", obs_v, 0);
      check("reset_done",  obs_d, 1);
      check("reset_0",     obs_0, 0);
      check("reset_1",     obs_1, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    push_exp(0, 10, 2, 2, 32);
    start(0, 0, 10, 2, 0);
    run("t1", 0, 0, 10);

    push_exp(0, 10, 2, 2, 32);
    start(0, 0, 10, 2, 0);
    run("t2", 1, 0, 10);

    start(0, 5, 5, 1, 0);
    run("t3a", 0, 0, 0);
    start(0, 0, 10, 0, 0);
    run("t3b", 0, 0, 0);

    push_exp(10, 0, -3, 1, 8);
    start(2, 10, 0, -3, 0);
    run("t4a", 0, 0, 4);
    push_exp(-2, 0, 1, 3, 32);
    start(1, -2, 0, 1, 0);
    run("t4b", 0, 0, 6);

    push_exp(120, 127, 5, 1, 8);
    start(2, 120, 127, 5, 0);
    run("t5a", 0, 0, 2);
    push_exp(100, -128, -100, 1, 8);
    start(2, 100, -128, -100, 0);
    run("t5b", 0, 0, 3);

    push_exp(0, 10, 1, 2, 32);
    start(0, 0, 10, 1, 0);
    run("t6a", 0, 3, 0);
    rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_valid", obs_v, 0);
    check("t6_rst_done",  obs_d, 1);
    exp_q.delete();

    push_exp(3, 5, 1, 2, 32);
    start(0, 3, 5, 1, 1);
    run("t6b", 0, 0, 4);

    push_exp(0, 10, 1, 2, 32);
    start(0, 0, 10, 1, 0);
    run("t6c", 0, 3, 0);
    exp_q.delete();
    push_exp(20, 23, 1, 2, 32);
    start(0, 20, 23, 1, 0);
    run("t6d", 0, 0, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
